// File: rtl/iot_pkg.sv
// rtl/iot_pkg.sv - shared constants, function codes and FSM encoding for the IoT stream transmitter
package iot_pkg;

    // Filter function codes carried on fn_sel
    localparam logic [2:0] FN_MAX     = 3'd1;
    localparam logic [2:0] FN_MIN     = 3'd2;
    localparam logic [2:0] FN_AVG     = 3'd3;
    localparam logic [2:0] FN_EXTRACT = 3'd4;
    localparam logic [2:0] FN_EXCLUDE = 3'd5;
    localparam logic [2:0] FN_PEAKMAX = 3'd6;
    localparam logic [2:0] FN_PEAKMIN = 3'd7;

    localparam int BYTES_PER_WORD  = 16;
    localparam int WORDS_PER_ROUND = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_t;

    // Byte k of a word, most significant byte first
    function automatic logic [7:0] word_byte(input logic [127:0] w, input logic [3:0] k);
        logic [127:0] sh;
        sh = w << {k, 3'b000};
        return sh[127:120];
    endfunction

endpackage

// File: rtl/iot_tx_fifo.sv
// rtl/iot_tx_fifo.sv - synchronous FIFO of 128-bit words with power-of-two depth
module iot_tx_fifo import iot_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [127:0] push_data,
    input  logic         pop,
    output logic [127:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [127:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop both take effect
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/iot_stream_tx.sv
// rtl/iot_stream_tx.sv - serialises buffered 128-bit words into filter byte strobes with round tracking
module iot_stream_tx import iot_pkg::*; #(
    parameter int FIFO_DEPTH      = 4,
    parameter int WORDS_PER_ROUND = iot_pkg::WORDS_PER_ROUND
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    input  logic [127:0] s_data,
    output logic         s_ready,
    input  logic [2:0]   cfg_fn,
    input  logic         busy,
    output logic         in_en,
    output logic [7:0]   iot_in,
    output logic [2:0]   fn_sel,
    output logic         round_done
);

    localparam logic [3:0] LAST_BYTE = 4'(BYTES_PER_WORD - 1);
    localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_ROUND - 1);

    tx_state_t    state;
    tx_state_t    next_state;
    logic [3:0]   k;
    logic [2:0]   word_cnt;
    logic         ready_q;
    logic         issue;
    logic         pop;
    logic         push;
    logic         fifo_full;
    logic         fifo_empty;
    logic [127:0] head;

    // ready_q keeps s_ready low through reset and for the first cycle after it
    assign s_ready = ready_q && !fifo_full;
    assign push    = s_valid && s_ready;

    iot_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (s_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and per-cycle byte issue / word pop decisions
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !busy) begin
                    next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!busy) begin
                    issue = 1'b1;
                    if (k == LAST_BYTE) begin
                        pop        = 1'b1;
                        next_state = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                next_state = fifo_empty ? ST_IDLE : ST_SEND;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Byte index and word-in-round counter; word count survives an empty FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            k        <= '0;
            word_cnt <= '0;
        end else if (issue) begin
            k <= k + 4'd1;
            if (k == LAST_BYTE) begin
                word_cnt <= (word_cnt == LAST_WORD) ? 3'd0 : word_cnt + 3'd1;
            end
        end
    end

    // Registered filter outputs; fn_sel latches only at the first byte of a round
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q    <= 1'b0;
            in_en      <= 1'b0;
            iot_in     <= '0;
            fn_sel     <= '0;
            round_done <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            in_en   <= issue;
            if (issue) begin
                iot_in <= word_byte(head, k);
            end
            if (issue && (k == 4'd0) && (word_cnt == 3'd0)) begin
                fn_sel <= cfg_fn;
            end
            // GAP with a wrapped word counter means the last word of a round just finished
            round_done <= (state == ST_GAP) && (word_cnt == 3'd0);
        end
    end

endmodule

// File: tb/tb_iot_stream_tx.sv
// tb/tb_iot_stream_tx.sv - scoreboard bench for iot_stream_tx
module tb_iot_stream_tx;

    typedef struct {
        logic [7:0] b;
        logic [2:0] fn;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic [127:0] s_data;
    logic         s_ready;
    logic [2:0]   cfg_fn;
    logic         busy;
    logic         in_en;
    logic [7:0]   iot_in;
    logic [2:0]   fn_sel;
    logic         round_done;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_vec  = 0;
    int n_miss = 0;
    int bytes_seen = 0;
    int idle_cnt = 0;
    int rd_seen = 0;
    bit rd_pend = 0;
    bit chk_gap = 0;
    logic       prev_busy = 1'b0;
    logic [7:0] last_byte = 8'h00;

    iot_stream_tx #(
        .FIFO_DEPTH(4),
        .WORDS_PER_ROUND(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .cfg_fn     (cfg_fn),
        .busy       (busy),
        .in_en      (in_en),
        .iot_in     (iot_in),
        .fn_sel     (fn_sel),
        .round_done (round_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [127:0] mk_word(input int n);
        logic [127:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            w = {w[119:0], 8'(n * 16 + i)};
        end
        return w;
    endfunction

    // Monitor: pops the scoreboard on every strobe and checks framing rules
    always @(negedge clk) begin
        if (rst) begin
            bytes_seen = 0;
            idle_cnt   = 0;
            rd_pend    = 0;
            last_byte  = 8'h00;
        end else begin
            if (round_done || rd_pend) begin
                chk("round_done", {127'd0, round_done}, {127'd0, rd_pend});
                if (round_done) rd_seen++;
            end
            rd_pend = 0;
            if (in_en) begin
                chk("issue_while_busy", {127'd0, prev_busy}, 128'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {120'd0, iot_in}, 128'hx);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("iot_in", {120'd0, iot_in}, {120'd0, mon_e.b});
                    chk("fn_sel", {125'd0, fn_sel}, {125'd0, mon_e.fn});
                end
                if (chk_gap && (bytes_seen % 16 == 0) && (bytes_seen != 0)) begin
                    chk("gap_cycles", 128'(idle_cnt), 128'd1);
                end
                bytes_seen++;
                last_byte = iot_in;
                idle_cnt  = 0;
                if (bytes_seen % 128 == 0) rd_pend = 1;
            end else begin
                chk("iot_in_hold", {120'd0, iot_in}, {120'd0, last_byte});
                idle_cnt++;
            end
        end
        prev_busy = busy;
    end

    task automatic push_word(input logic [127:0] d, input logic [2:0] fn);
        bit rd;
        int t;
        logic [127:0] sh;
        exp_t e;
        t = 0;
        s_valid = 1'b1;
        s_data  = d;
        do begin
            rd = s_ready;
            if (rd) begin
                sh = d;
                for (int i = 0; i < 16; i++) begin
                    e.b  = sh[127:120];
                    e.fn = fn;
                    exp_q.push_back(e);
                    sh = sh << 8;
                end
            end
            @(posedge clk);
            #1;
            t++;
        end while (!rd && t < 500);
        if (!rd) chk("push_timeout", 128'd0, 128'd1);
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        busy    = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        chk("rst_in_en",      {127'd0, in_en},      128'd0);
        chk("rst_iot_in",     {120'd0, iot_in},     128'd0);
        chk("rst_fn_sel",     {125'd0, fn_sel},     128'd0);
        chk("rst_round_done", {127'd0, round_done}, 128'd0);
        chk("rst_s_ready",    {127'd0, s_ready},    128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("s_ready_after_rst", {127'd0, s_ready}, 128'd1);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", 128'(exp_q.size()), 128'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        bit ready_dropped;
        int t;
        int rd_base;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        cfg_fn  = 3'd0;
        busy    = 1'b0;
        do_reset();

        // Single word, busy low: two-cycle latency, sixteen bytes, s_ready stays high
        cfg_fn = 3'd1;
        push_word(128'h00112233445566778899AABBCCDDEEFF, 3'd1);
        chk("latency_c0", {127'd0, in_en}, 128'd0);
        @(posedge clk); #1;
        chk("latency_c1", {127'd0, in_en}, 128'd0);
        @(posedge clk); #1;
        chk("latency_c2", {127'd0, in_en}, 128'd1);
        chk("first_byte", {120'd0, iot_in}, 128'h00);
        ready_dropped = 0;
        for (int i = 0; i < 20; i++) begin
            if (!s_ready) ready_dropped = 1;
            @(posedge clk); #1;
        end
        chk("s_ready_stays", {127'd0, ready_dropped}, 128'd0);
        wait_drain();

        // Busy stall after byte 5; cfg change mid-round is ignored
        cfg_fn = 3'd2;
        push_word(128'h0F0E0D0C0B0A09080706050403020100, 3'd1);
        t = 0;
        while (!(in_en && iot_in == 8'h0A) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("found_byte5", {120'd0, iot_in}, 128'h0A);
        busy = 1'b1;
        @(posedge clk); #1;
        chk("busy_stall_1", {127'd0, in_en}, 128'd0);
        @(posedge clk); #1;
        chk("busy_stall_2", {127'd0, in_en}, 128'd0);
        busy = 1'b0;
        @(posedge clk); #1;
        chk("resume_en", {127'd0, in_en}, 128'd1);
        chk("resume_byte", {120'd0, iot_in}, 128'h09);
        wait_drain();

        // Six words through a four-deep FIFO, one GAP between words
        do_reset();
        chk_gap = 1;
        cfg_fn = 3'd1;
        for (int i = 0; i < 4; i++) push_word(mk_word(i), 3'd1);
        chk("full_s_ready", {127'd0, s_ready}, 128'd0);
        for (int i = 4; i < 6; i++) push_word(mk_word(i), 3'd1);
        wait_drain();
        chk_gap = 0;

        // Two rounds: fn_sel follows cfg_fn only at round start, one round_done
        do_reset();
        chk_gap = 1;
        rd_base = rd_seen;
        cfg_fn = 3'd3;
        for (int i = 0; i < 4; i++) push_word(mk_word(i + 6), 3'd3);
        cfg_fn = 3'd6;
        for (int i = 4; i < 8; i++) push_word(mk_word(i + 6), 3'd3);
        push_word(mk_word(14), 3'd6);
        wait_drain();
        chk("round_done_count", 128'(rd_seen - rd_base), 128'd1);
        chk_gap = 0;

        // Reset at byte 9 of word 2 discards everything; new word restarts the round
        do_reset();
        cfg_fn = 3'd4;
        for (int i = 0; i < 3; i++) push_word(mk_word(i + 1), 3'd4);
        t = 0;
        while (!(in_en && bytes_seen == 41) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("mid_word_byte9", {120'd0, iot_in}, 128'h39);
        do_reset();
        cfg_fn = 3'd5;
        push_word(mk_word(11), 3'd5);
        wait_drain();
        chk("post_rst_fn_sel", {125'd0, fn_sel}, 128'd5);
        repeat (30) @(posedge clk);
        #1;
        chk("no_stale_bytes", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/iot_stream_tx.md
IOT_STREAM_TX -- requirements
Module: iot_stream_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of 128-bit word entries buffered; power of two, at least 2.
REQ-002 Parameter WORDS_PER_ROUND, default 8, number of words per filter round.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 s_valid  input  1  upstream word valid.
REQ-006 s_data  input  128  upstream word; bits 127:120 are sent first.
REQ-007 s_ready  output  1  word accepted when s_valid and s_ready are both high at a clock edge.
REQ-008 cfg_fn  input  3  requested filter function code (1..7).
REQ-009 busy  input  1  filter busy; no byte may be issued while it is high.
REQ-010 in_en  output  1  byte strobe to the filter, registered.
REQ-011 iot_in  output  8  byte to the filter, registered.
REQ-012 fn_sel  output  3  function select to the filter, registered.
REQ-013 round_done  output  1  one-cycle pulse after the final byte of each round.

Function
REQ-014 Words SHALL be stored in a FIFO of FIFO_DEPTH entries; s_ready SHALL equal not-full.
REQ-015 A word SHALL be popped only in the cycle its 16th byte is issued; a push and a pop in the same cycle SHALL both take effect.
REQ-016 The FSM SHALL have three states: IDLE, SEND and GAP.
REQ-017 IDLE -> SEND when the FIFO is non-empty and busy is low; otherwise the FSM stays in IDLE.
REQ-018 In SEND, each cycle with busy low SHALL register in_en=1 and iot_in = head byte [127-8k -: 8], where k is a 4-bit byte index, then increment k.
REQ-019 In SEND, a cycle with busy high SHALL register in_en=0 and hold k; the word resumes at the same k with no byte skipped or repeated.
REQ-020 After byte k=15 is issued: pop the FIFO, k wraps to 0, state -> GAP.
REQ-021 GAP SHALL last exactly one cycle with in_en=0, then go to SEND if the FIFO is non-empty, otherwise to IDLE.
REQ-022 When the FIFO empties mid-round, the word counter SHALL be kept; the round resumes with the next word.
REQ-023 iot_in SHALL hold its last value whenever in_en=0.
REQ-024 A 3-bit word counter SHALL count words issued, 0..WORDS_PER_ROUND-1, and wrap to 0.
REQ-025 fn_sel SHALL be loaded from cfg_fn only when byte 0 of word 0 of a round is issued; cfg_fn changes mid-round SHALL be ignored until the next round.
REQ-026 A cfg_fn value of 0 SHALL be loaded unchanged; the block does not check it.
REQ-027 round_done SHALL pulse high in the cycle after byte 15 of word WORDS_PER_ROUND-1 is issued.
REQ-028 Latency: a word pushed into an empty FIFO while in IDLE with busy low SHALL produce its first in_en two cycles after the push edge.

Reset
REQ-029 While rst is high at a clock edge: state=IDLE, k=0, word counter=0, FIFO empty, s_ready=0.
REQ-030 While rst is high at a clock edge: in_en=0, iot_in=0, fn_sel=0, round_done=0.
REQ-031 s_ready SHALL rise one cycle after rst is released.
REQ-032 A reset in mid-word or mid-round SHALL discard the partial word and all buffered words; no further bytes of them are issued.

Structure
REQ-033 Shared package iot_pkg SHALL hold: the function codes MAX=1, MIN=2, AVG=3, EXTRACT=4, EXCLUDE=5, PEAKMAX=6, PEAKMIN=7; BYTES_PER_WORD=16; the default WORDS_PER_ROUND=8.
REQ-034 The FSM state encoding SHALL also live in iot_pkg.
REQ-035 The FIFO SHALL be a separate sub-module, iot_tx_fifo (128-bit data, parameterised depth, synchronous reset); the FSM, counters and output registers live in iot_stream_tx.

Verification
REQ-036 Single word, busy=0, s_data=128'h0011..EEFF -> 16 consecutive in_en cycles, iot_in=00,11,...,FF, s_ready stays 1.
REQ-037 busy pulse during byte 5 of word 0x0F0E..00 -> in_en drops for exactly the busy cycles, next byte is 0x09, total 16 bytes.
REQ-038 Push 6 words with FIFO_DEPTH=4 and busy=0 -> s_ready low after 4 buffered; all 6 words issued in order, with one GAP cycle between words.
REQ-039 cfg_fn=3 for word 0, changed to 6 at word 4 -> fn_sel=3 for all of round 1, fn_sel=6 from byte 0 of round 2, round_done pulses after 128 bytes.
REQ-040 rst asserted at byte 9 of word 2 -> next cycle in_en=0, iot_in=0, fn_sel=0, FIFO empty; a new word after reset starts at byte 0 and word counter 0.
